// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - memory-side load/store responder with configurable wait states
//
// Purpose: accepts load/store requests from the memory stage, aligns store
// data onto byte lanes, performs byte-enabled writes into an internal word
// array and returns the raw word-aligned load word. A wait-state FSM inserts
// WAIT_CYCLES extra cycles between acceptance and response.
//
// Ports:
//   clk        - clock, all state on rising edge
//   resetn     - asynchronous active-low reset
//   req_valid  - request present
//   req_ready  - request can be accepted this cycle (combinational)
//   req_write  - 1 = store, 0 = load
//   req_size   - 0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_addr   - byte address
//   req_wdata  - store data, right-justified
//   rsp_valid  - one-cycle response strobe
//   rsp_rdata  - raw aligned word for loads, 0 for stores and errors
//   rsp_err    - misaligned, illegal size or out-of-range request

module rv32_dmem_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         ADDR_BITS = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [MEM_WORDS];

    logic        accept;
    logic        go_resp;

    // Request actually serviced on the edge that enters RESP.
    logic                 a_write;
    logic [1:0]           a_size;
    logic [31:0]          a_addr;
    logic [31:0]          a_wdata;
    logic                 a_err;
    logic [ADDR_BITS-1:0] a_index;
    logic [3:0]           a_be;
    logic [31:0]          a_data;
    logic                 mem_we;

    assign req_ready = (state != WAIT);
    assign accept    = req_valid && req_ready;

    // With no wait states the accepting edge is also the access edge; otherwise
    // the access happens on the edge that leaves WAIT with the counter at zero.
    assign go_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd0));

    // Outside WAIT the only way to reach RESP is the current acceptance, whose
    // request has not landed in the capture registers yet, so use the inputs.
    always_comb begin
        if (state == WAIT) begin
            a_write = cap_write;
            a_size  = cap_size;
            a_addr  = cap_addr;
            a_wdata = cap_wdata;
        end else begin
            a_write = req_write;
            a_size  = req_size;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end
    end

    assign a_index = a_addr[ADDR_BITS+1:2];

    always_comb begin
        a_err = 1'b0;
        case (a_size)
            2'd0:    a_err = 1'b0;
            2'd1:    a_err = a_addr[0];
            2'd2:    a_err = |a_addr[1:0];
            default: a_err = 1'b1;
        endcase
        if ((a_addr >> (ADDR_BITS + 2)) != 32'd0) begin
            a_err = 1'b1;
        end
    end

    // Replicate the store data so every enabled lane already holds its byte.
    always_comb begin
        a_be   = 4'b1111;
        a_data = a_wdata;
        case (a_size)
            2'd0: begin
                a_be   = 4'b0001 << a_addr[1:0];
                a_data = {4{a_wdata[7:0]}};
            end
            2'd1: begin
                a_be   = a_addr[1] ? 4'b1100 : 4'b0011;
                a_data = {2{a_wdata[15:0]}};
            end
            default: begin
                a_be   = 4'b1111;
                a_data = a_wdata;
            end
        endcase
    end

    // resetn gates the write so nothing lands in the array while held in reset.
    assign mem_we = go_resp && a_write && !a_err && resetn;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) begin
                    mem[a_index][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            cap_write <= 1'b0;
            cap_size  <= 2'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else begin
            rsp_valid <= go_resp;
            rsp_err   <= go_resp && a_err;
            rsp_rdata <= (go_resp && !a_write && !a_err) ? mem[a_index] : 32'd0;

            if (accept) begin
                cap_write <= req_write;
                cap_size  <= req_size;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end

            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - self-checking bench for rv32_dmem_responder

module tb_rv32_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        rv    [2];
    logic        rw    [2];
    logic [1:0]  rs    [2];
    logic [31:0] ra    [2];
    logic [31:0] rd    [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic [31:0] rdata [2];
    logic        er    [2];

    rv32_dmem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]), .req_size(rs[0]),
        .req_addr(ra[0]), .req_wdata(rd[0]),
        .rsp_valid(vld[0]), .rsp_rdata(rdata[0]), .rsp_err(er[0])
    );

    rv32_dmem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .resetn(resetn),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]), .req_size(rs[1]),
        .req_addr(ra[1]), .req_wdata(rd[1]),
        .rsp_valid(vld[1]), .rsp_rdata(rdata[1]), .rsp_err(er[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference memories: one plain word array per DUT, byte-indexed updates.
    logic [31:0] ref0 [1024];
    logic [31:0] ref1 [1024];

    task automatic model(input int idx, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] r);
        int          nbytes;
        int          word;
        int          lane;
        logic [31:0] cur;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || ((a % nbytes) != 0) || (a >= 32'd4096);
        r = 32'd0;
        if (!e) begin
            word = int'(a / 4);
            cur  = (idx == 0) ? ref0[word] : ref1[word];
            if (w) begin
                for (int k = 0; k < nbytes; k++) begin
                    lane = int'(a % 4) + k;
                    cur[8*lane +: 8] = wd[8*k +: 8];
                end
                if (idx == 0) ref0[word] = cur;
                else          ref1[word] = cur;
            end else begin
                r = cur;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int idx, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit track = 1'b1, input bit use_exp = 1'b0,
                         input logic e_err = 1'b0, input logic [31:0] e_rd = 32'd0);
        exp_t        x;
        logic        me;
        logic [31:0] mr;
        int          waited;
        rv[idx] = 1'b1;
        rw[idx] = w;
        rs[idx] = sz;
        ra[idx] = a;
        rd[idx] = wd;
        if (idx == 0) check_eq("ready_w0", {31'd0, rdy[0]}, 32'd1);
        waited = 0;
        while (!rdy[idx] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[idx]) begin
            check_eq("ready_timeout", {31'd0, rdy[idx]}, 32'd1);
            rv[idx] = 1'b0;
            return;
        end
        if (track) begin
            model(idx, w, sz, a, wd, me, mr);
            x.due   = cyc + 1 + ((idx == 0) ? 0 : 3);
            x.err   = use_exp ? e_err : me;
            x.rdata = use_exp ? e_rd : mr;
            if (idx == 0) q0.push_back(x);
            else          q1.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int idx, input int n);
        rv[idx] = 1'b0;
        for (int i = 0; i < n; i++) begin
            rw[idx] = 1'($urandom);
            rs[idx] = 2'($urandom);
            ra[idx] = $urandom;
            rd[idx] = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic rand_req(input int idx);
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        w = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 15);
        sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
        if ($urandom_range(0, 19) == 0) a = 32'h1000 | $urandom;
        else                            a = 32'($urandom_range(0, 255));
        issue(idx, w, sz, a, $urandom);
    endtask

    exp_t m0;
    exp_t m1;

    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            m0 = q0.pop_front();
            check_eq("rsp_valid0", {31'd0, vld[0]}, 32'd1);
            check_eq("rsp_err0", {31'd0, er[0]}, {31'd0, m0.err});
            check_eq("rsp_rdata0", rdata[0], m0.rdata);
        end else if (vld[0]) begin
            check_eq("rsp_unexpected0", {31'd0, vld[0]}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            m1 = q1.pop_front();
            check_eq("rsp_valid3", {31'd0, vld[1]}, 32'd1);
            check_eq("rsp_err3", {31'd0, er[1]}, {31'd0, m1.err});
            check_eq("rsp_rdata3", rdata[1], m1.rdata);
        end else if (vld[1]) begin
            check_eq("rsp_unexpected3", {31'd0, vld[1]}, 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref0[i] = 32'd0;
            ref1[i] = 32'd0;
        end
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; rs[i] = 2'd0; ra[i] = 32'd0; rd[i] = 32'd0;
        end
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_ready", {31'd0, rdy[i]}, 32'd1);
            check_eq("reset_valid", {31'd0, vld[i]}, 32'd0);
            check_eq("reset_rdata", rdata[i], 32'd0);
            check_eq("reset_err", {31'd0, er[i]}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);

        // Known contents for words 0..63 of both memories.
        for (int i = 0; i < 64; i++) issue(0, 1'b1, 2'd2, 32'(i * 4), 32'd0);
        idle(0, 2);
        for (int i = 0; i < 64; i++) issue(1, 1'b1, 2'd2, 32'(i * 4), 32'd0);
        idle(1, 6);

        // Store then load back-to-back.
        issue(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1, 1, 1'b0, 32'd0);
        issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1, 1, 1'b0, 32'hDEADBEEF);
        // Byte and half merges into the same word.
        issue(0, 1'b1, 2'd0, 32'h11, 32'h000000AA, 1, 1, 1'b0, 32'd0);
        issue(0, 1'b1, 2'd1, 32'h12, 32'h00001234, 1, 1, 1'b0, 32'd0);
        issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1, 1, 1'b0, 32'h1234AAEF);
        idle(0, 2);
        // Error cases must leave memory untouched.
        issue(0, 1'b0, 2'd1, 32'h13, 32'h0, 1, 1, 1'b1, 32'd0);
        issue(0, 1'b1, 2'd2, 32'h22, 32'hFFFFFFFF, 1, 1, 1'b1, 32'd0);
        issue(0, 1'b1, 2'd3, 32'h20, 32'h11111111, 1, 1, 1'b1, 32'd0);
        issue(0, 1'b0, 2'd2, 32'h00010000, 32'h0, 1, 1, 1'b1, 32'd0);
        issue(0, 1'b1, 2'd2, 32'h00010020, 32'h22222222, 1, 1, 1'b1, 32'd0);
        issue(0, 1'b0, 2'd2, 32'h20, 32'h0, 1, 1, 1'b0, 32'd0);
        idle(0, 1);
        // Three consecutive byte loads return the full word each time.
        issue(0, 1'b1, 2'd2, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0, 32'd0);
        idle(0, 1);
        issue(0, 1'b0, 2'd0, 32'h1, 32'h0, 1, 1, 1'b0, 32'hCAFEF00D);
        issue(0, 1'b0, 2'd0, 32'h2, 32'h0, 1, 1, 1'b0, 32'hCAFEF00D);
        issue(0, 1'b0, 2'd0, 32'h3, 32'h0, 1, 1, 1'b0, 32'hCAFEF00D);
        idle(0, 2);

        for (int i = 0; i < 300; i++) begin
            rand_req(0);
            if ($urandom_range(0, 9) < 3) idle(0, $urandom_range(1, 2));
        end
        idle(0, 4);

        // Wait-state timing on the WAIT_CYCLES = 3 instance.
        issue(1, 1'b1, 2'd2, 32'h40, 32'hA5A50F0F, 1, 1, 1'b0, 32'd0);
        issue(1, 1'b0, 2'd2, 32'h40, 32'h0, 1, 1, 1'b0, 32'hA5A50F0F);
        rv[1] = 1'b1; rw[1] = 1'b1; rs[1] = 2'd2; ra[1] = 32'h44; rd[1] = 32'h0BADF00D;
        for (int i = 0; i < 3; i++) begin
            check_eq("wait_ready_low", {31'd0, rdy[1]}, 32'd0);
            @(negedge clk);
        end
        check_eq("wait_ready_back", {31'd0, rdy[1]}, 32'd1);
        check_eq("wait_rsp_at_t4", {31'd0, vld[1]}, 32'd1);
        issue(1, 1'b1, 2'd2, 32'h44, 32'h0BADF00D, 1, 1, 1'b0, 32'd0);
        issue(1, 1'b0, 2'd2, 32'h44, 32'h0, 1, 1, 1'b0, 32'h0BADF00D);
        idle(1, 6);

        // Reset while a store waits: the store is dropped.
        issue(1, 1'b1, 2'd2, 32'h30, 32'h55555555, 0);
        rv[1] = 1'b0;
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_valid", {31'd0, vld[1]}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, rdy[1]}, 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue(1, 1'b0, 2'd2, 32'h30, 32'h0, 1, 1, 1'b0, 32'd0);
        idle(1, 6);

        for (int i = 0; i < 80; i++) begin
            rand_req(1);
            if ($urandom_range(0, 9) < 3) idle(1, $urandom_range(1, 5));
        end
        idle(1, 8);
        idle(0, 2);

        check_eq("q0_drained", 32'(q0.size()), 32'd0);
        check_eq("q3_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
